instruction_decode: RTL
=======================

# instruction_decode

Decode stage of the five-stage RV32I pipeline, directly downstream of instruction fetch. Captures the fetched `inst` in an IF/ID latch, decodes it, reads the 32x32 register file and drives registered ID/EX outputs to execute. Produces the branch offset and branch flag that fetch consumes. Detects load-use hazards and inserts bubbles; honours `flush` from fetch.

## Interface
- `NOP`, 32'h00000013: instruction loaded into IF/ID on reset or flush (addi x0,x0,0).
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst` in 32: instruction from fetch.
- `flush` in 1: from fetch; squash IF/ID and ID/EX contents.
- `wbEn` in 1: write-back enable.
- `wbAddr` in 5: write-back register index.
- `wbData` in 32: write-back data.
- `stall` out 1: combinational load-use stall; fetch holds its PC while high.
- `rs1Data`, `rs2Data` out 32: registered operands.
- `imm` out 32: registered sign-extended immediate (I, S or B format).
- `rd` out 5: registered destination index.
- `aluOp` out 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 SRA.
- `aluSrc` out 1: 1 = `imm` is operand B.
- `memRead`, `memWrite`, `regWrite`, `memToReg` out 1: registered controls.
- `branchFlag` out 1: registered; 1 for beq.
- `branchOffset` out 32: registered B-immediate, sign-extended, byte units.
- `valid` out 1: ID/EX holds a real instruction.
- `illegal` out 1: registered; unsupported opcode/funct was decoded.

## Operation
- Supported ops:
  - R-type: add, sub, and, or, xor, slt, sll, srl, sra.
  - I-type: addi, andi, ori, xori, slti.
  - lw, sw, beq.
- Any other encoding decodes as a bubble with `illegal`=1 for one cycle.
- Register file: x0 reads 0, writes to x0 ignored.
  - Write on rising edge when `wbEn`.
  - Write-through: read of `wbAddr` in the same cycle returns `wbData`.
- Register usage:
  - rs2 is used only by R-type, sw and beq.
  - rs1 is used by all supported ops.
- Control per op:
  - lw: memRead, regWrite, memToReg, aluSrc, ADD.
  - sw: memWrite, aluSrc, ADD, S-imm.
  - beq: SUB, branchFlag, regWrite=0.
  - I-ALU: aluSrc, regWrite.
  - R-type: regWrite.
- Load-use hazard: `stall`=1 when all of the following hold:
  - ID/EX `memRead`=1 and `valid`=1;
  - `rd`≠0;
  - `rd` equals a used rs1/rs2 of the IF/ID instruction.
- Stall response: IF/ID holds; ID/EX loads a bubble (all controls 0, `valid`=0).
- Flush: IF/ID loads `NOP` and ID/EX loads a bubble. Flush overrides stall; `stall` is forced 0 while `flush`=1.
- Bubble/NOP data outputs are don't-care except `rd`=0.

## Timing
- Reset (async, immediate):
  - IF/ID = `NOP`.
  - All registered outputs 0, `valid`=0.
  - All 32 registers cleared to 0.
- Latency: inst sampled at edge N appears decoded on outputs after edge N+1.
- A stall lasts exactly one cycle per load-use pair. The following cycle the load has left ID/EX, so `stall` deasserts.
- `flush` sampled at edge N:
  - the instruction present on `inst` at N is discarded;
  - outputs after N are a bubble;
  - the next real instruction appears after N+2.
- Simultaneous write-back to rs and decode: bypassed value is registered.
- Reset mid-stall: stall drops at once; the held instruction is lost.

## Test plan
- Reset: assert `rst` 10 ns mid-run. All outputs 0, `valid`=0, `stall`=0. After release, two NOP cycles yield `valid`=1, `aluOp`=0, `rd`=0.
- addi: 0x00500093 decoded → `imm`=5, `rd`=1, `aluSrc`=1, `regWrite`=1, `aluOp`=0. `rs1Data`=0.
- Write-through: `wbEn`=1, `wbAddr`=1, `wbData`=0x12345678 in the same cycle as add x3,x2,x1 (0x001101B3) is decoded → `rs2Data`=0x12345678. A write to x0 leaves x0 reading 0.
- Load-use:
  - Sequence lw x2,0(x1) (0x0000A103) then add x3,x2,x1 → `stall`=1 for exactly one cycle and one bubble.
  - add then appears with `rd`=3.
  - Same pair with add using x5 instead → no stall.
- beq: 0xFE2088E3 → `branchFlag`=1, `branchOffset`=0xFFFFFFF0, `aluOp`=1, `regWrite`=0.
- Flush: `flush`=1 during a stall cycle → next outputs are a bubble, `stall`=0, and the held add is discarded. Opcode 0x7F → `illegal`=1, `valid`=0.

Source files
------------

// File: rtl/instruction_decode.sv
// RV32I decode stage: IF/ID latch, decoder, 32x32 register file with write-through,
// load-use hazard detection and the registered ID/EX bundle handed to execute.
module instruction_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        flush,
    input  logic        wbEn,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    output logic        stall,
    output logic [31:0] rs1Data,
    output logic [31:0] rs2Data,
    output logic [31:0] imm,
    output logic [4:0]  rd,
    output logic [3:0]  aluOp,
    output logic        aluSrc,
    output logic        memRead,
    output logic        memWrite,
    output logic        regWrite,
    output logic        memToReg,
    output logic        branchFlag,
    output logic [31:0] branchOffset,
    output logic        valid,
    output logic        illegal
);

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_I      = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
        ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_SRA = 4'd8
    } alu_op_e;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        memRead;
        logic        memWrite;
        logic        regWrite;
        logic        memToReg;
        logic        aluSrc;
        logic        branchFlag;
        logic [3:0]  aluOp;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [31:0] branchOffset;
    } idex_t;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    logic [31:0] ifid_q, ifid_d;
    logic [31:0] rf_q [32];
    idex_t       idex_q, idex_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_val, rs2_val;

    logic        dec_legal, dec_use_rs2;
    logic        dec_aluSrc, dec_memRead, dec_memWrite, dec_regWrite, dec_memToReg, dec_branch;
    alu_op_e     dec_aluOp;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rd;
    logic        hazard;

    assign opcode = ifid_q[6:0];
    assign funct3 = ifid_q[14:12];
    assign funct7 = ifid_q[31:25];
    assign rs1    = ifid_q[19:15];
    assign rs2    = ifid_q[24:20];

    // ---- IF/ID boundary ----
    always_comb begin
        ifid_d = inst;
        if (flush)      ifid_d = NOP;
        else if (stall) ifid_d = ifid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ifid_q <= NOP;
        else     ifid_q <= ifid_d;
    end

    always_comb begin
        dec_legal    = 1'b0;
        dec_use_rs2  = 1'b0;
        dec_aluSrc   = 1'b0;
        dec_memRead  = 1'b0;
        dec_memWrite = 1'b0;
        dec_regWrite = 1'b0;
        dec_memToReg = 1'b0;
        dec_branch   = 1'b0;
        dec_aluOp    = ALU_ADD;
        dec_imm      = imm_i(ifid_q);
        dec_rd       = ifid_q[11:7];
        unique case (opcode)
            OP_R: begin
                dec_legal    = 1'b1;
                dec_use_rs2  = 1'b1;
                dec_regWrite = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: dec_aluOp = ALU_ADD;
                    10'b0100000_000: dec_aluOp = ALU_SUB;
                    10'b0000000_111: dec_aluOp = ALU_AND;
                    10'b0000000_110: dec_aluOp = ALU_OR;
                    10'b0000000_100: dec_aluOp = ALU_XOR;
                    10'b0000000_010: dec_aluOp = ALU_SLT;
                    10'b0000000_001: dec_aluOp = ALU_SLL;
                    10'b0000000_101: dec_aluOp = ALU_SRL;
                    10'b0100000_101: dec_aluOp = ALU_SRA;
                    default:         dec_legal = 1'b0;
                endcase
            end
            OP_I: begin
                dec_legal    = 1'b1;
                dec_aluSrc   = 1'b1;
                dec_regWrite = 1'b1;
                case (funct3)
                    3'b000:  dec_aluOp = ALU_ADD;
                    3'b111:  dec_aluOp = ALU_AND;
                    3'b110:  dec_aluOp = ALU_OR;
                    3'b100:  dec_aluOp = ALU_XOR;
                    3'b010:  dec_aluOp = ALU_SLT;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_LOAD: begin
                dec_legal    = (funct3 == 3'b010);
                dec_memRead  = 1'b1;
                dec_regWrite = 1'b1;
                dec_memToReg = 1'b1;
                dec_aluSrc   = 1'b1;
            end
            OP_STORE: begin
                dec_legal    = (funct3 == 3'b010);
                dec_use_rs2  = 1'b1;
                dec_memWrite = 1'b1;
                dec_aluSrc   = 1'b1;
                dec_imm      = imm_s(ifid_q);
                dec_rd       = 5'd0;
            end
            OP_BRANCH: begin
                dec_legal    = (funct3 == 3'b000);
                dec_use_rs2  = 1'b1;
                dec_branch   = 1'b1;
                dec_aluOp    = ALU_SUB;
                dec_imm      = imm_b(ifid_q);
                dec_rd       = 5'd0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Write-through so a value retiring this cycle reaches the registered operand.
    always_comb begin
        rs1_val = rf_q[rs1];
        if (rs1 == 5'd0)                     rs1_val = '0;
        else if (wbEn && (wbAddr == rs1))    rs1_val = wbData;
        rs2_val = rf_q[rs2];
        if (rs2 == 5'd0)                     rs2_val = '0;
        else if (wbEn && (wbAddr == rs2))    rs2_val = wbData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else if (wbEn && (wbAddr != 5'd0)) begin
            rf_q[wbAddr] <= wbData;
        end
    end

    assign hazard = idex_q.memRead && idex_q.valid && (idex_q.rd != 5'd0) && dec_legal &&
                    ((idex_q.rd == rs1) || (dec_use_rs2 && (idex_q.rd == rs2)));
    assign stall  = hazard && !flush;

    // ---- ID/EX boundary ----
    always_comb begin
        idex_d              = '0;
        idex_d.imm          = dec_imm;
        idex_d.rs1Data      = rs1_val;
        idex_d.rs2Data      = rs2_val;
        idex_d.branchOffset = imm_b(ifid_q);
        if (!flush) begin
            if (!dec_legal) begin
                idex_d.illegal = 1'b1;
            end else if (!hazard) begin
                idex_d.valid      = 1'b1;
                idex_d.memRead    = dec_memRead;
                idex_d.memWrite   = dec_memWrite;
                idex_d.regWrite   = dec_regWrite;
                idex_d.memToReg   = dec_memToReg;
                idex_d.aluSrc     = dec_aluSrc;
                idex_d.branchFlag = dec_branch;
                idex_d.aluOp      = dec_aluOp;
                idex_d.rd         = dec_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign valid        = idex_q.valid;
    assign illegal      = idex_q.illegal;
    assign memRead      = idex_q.memRead;
    assign memWrite     = idex_q.memWrite;
    assign regWrite     = idex_q.regWrite;
    assign memToReg     = idex_q.memToReg;
    assign aluSrc       = idex_q.aluSrc;
    assign branchFlag   = idex_q.branchFlag;
    assign aluOp        = idex_q.aluOp;
    assign rd           = idex_q.rd;
    assign imm          = idex_q.imm;
    assign rs1Data      = idex_q.rs1Data;
    assign rs2Data      = idex_q.rs2Data;
    assign branchOffset = idex_q.branchOffset;

endmodule
